// File: rtl/router_port_scheduler.sv
// router_port_scheduler
// Round-robin scheduler that shares one router output port among N_PORTS
// input FIFOs. In IDLE it picks the next non-empty FIFO after the previous
// owner. In XFER it strobes reads to that owner while the output accepts data.
//
// Ports:
//   clk_i         clock, rising edge
//   rst_ni        asynchronous active-low reset
//   fifo_empty_i  per-FIFO empty flag
//   eop_i         per-FIFO head-of-line end-of-packet flag
//   out_ready_i   output port accepts a beat this cycle
//   rd_o          one-hot read strobe to the owner's FIFO manager (combinational)
//   grant_o       one-hot current owner, zero when idle (registered)
//   grant_id_o    index of current owner, drives the output mux (registered)
//   valid_o       owner has a head word available (combinational)
//   busy_o        high while in XFER (registered)
//
// Build option:
//   ROUTER_PKT_LOCK_EN  defined   : hold the grant until the owner's eop beat
//                       undefined : release after MAX_BURST beats or when the
//                                   owner runs empty; eop_i is ignored
//
// state | meaning
// IDLE  | no owner; choose a round-robin winner among non-empty FIFOs
// XFER  | owner fixed; read on ready cycles until a release condition
module router_port_scheduler #(
    parameter int N_PORTS   = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [N_PORTS-1:0]         fifo_empty_i,
    input  logic [N_PORTS-1:0]         eop_i,
    input  logic                       out_ready_i,
    output logic [N_PORTS-1:0]         rd_o,
    output logic [N_PORTS-1:0]         grant_o,
    output logic [$clog2(N_PORTS)-1:0] grant_id_o,
    output logic                       valid_o,
    output logic                       busy_o
);

    localparam int IDW = $clog2(N_PORTS);
    localparam logic [N_PORTS-1:0] ONE_HOT0 = N_PORTS'(1);
    localparam logic [IDW-1:0]     LAST_ID  = IDW'(N_PORTS - 1);

    typedef enum logic {
        IDLE,
        XFER
    } state_t;

    state_t             state;
    logic [IDW-1:0]     last_ptr;
    logic               found;
    logic [IDW-1:0]     win_id;
    logic [IDW-1:0]     cand;
    logic [N_PORTS-1:0] win_oh;
    logic               cur_empty;
    logic               beat;
    logic               rel_xfer;

    // Search starts one past the previous owner and wraps by explicit
    // compare, so non-power-of-two port counts wrap correctly.
    always_comb begin
        found  = 1'b0;
        win_id = '0;
        cand   = last_ptr;
        for (int i = 0; i < N_PORTS; i++) begin
            if (cand == LAST_ID) cand = '0;
            else                 cand = cand + IDW'(1);
            if (!found && !fifo_empty_i[cand]) begin
                found  = 1'b1;
                win_id = cand;
            end
        end
    end

    assign win_oh    = ONE_HOT0 << win_id;
    assign cur_empty = fifo_empty_i[grant_id_o];
    assign beat      = (state == XFER) && out_ready_i && !cur_empty;
    assign rd_o      = beat ? grant_o : '0;
    assign valid_o   = (state == XFER) && !cur_empty;

`ifdef ROUTER_PKT_LOCK_EN
    // Packet locking: an empty owner simply stalls; only the eop beat frees
    // the port.
    localparam int unused_max_burst = MAX_BURST;
    assign rel_xfer = beat && eop_i[grant_id_o];
`else
    localparam int CW = $clog2(MAX_BURST) + 1;

    logic [CW-1:0] beat_cnt;
    logic          unused_eop;

    assign unused_eop = ^eop_i;

    // The beat that makes beat_cnt reach MAX_BURST is the last one. An empty
    // owner gives the port up at once instead of holding it.
    assign rel_xfer = (state == XFER) &&
                      (cur_empty || (beat && (beat_cnt == CW'(MAX_BURST - 1))));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            beat_cnt <= '0;
        end else if (state == IDLE) begin
            beat_cnt <= '0;
        end else if (beat) begin
            beat_cnt <= beat_cnt + CW'(1);
        end
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            last_ptr   <= LAST_ID;
            grant_o    <= '0;
            grant_id_o <= '0;
            busy_o     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_o    <= win_oh;
                        grant_id_o <= win_id;
                        busy_o     <= 1'b1;
                        state      <= XFER;
                    end
                end
                XFER: begin
                    // grant_id_o is left alone so the mux select stays stable
                    // through the idle cycle.
                    if (rel_xfer) begin
                        last_ptr <= grant_id_o;
                        grant_o  <= '0;
                        busy_o   <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_router_port_scheduler.sv
// Bench for router_port_scheduler. A small FIFO model supplies the empty and
// eop flags. Each expected grant (owner, beat count) is pushed to a queue when
// the FIFOs are loaded. Grants are popped and compared as the DUT issues them.
module tb_router_port_scheduler;

    localparam int N  = 4;
    localparam int MB = 4;
`ifdef ROUTER_PKT_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic [N-1:0] fifo_empty_i;
    logic [N-1:0] eop_i;
    logic         out_ready_i;
    logic [N-1:0] rd_o;
    logic [N-1:0] grant_o;
    logic [1:0]   grant_id_o;
    logic         valid_o;
    logic         busy_o;

    router_port_scheduler #(.N_PORTS(N), .MAX_BURST(MB)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .fifo_empty_i(fifo_empty_i),
        .eop_i       (eop_i),
        .out_ready_i (out_ready_i),
        .rd_o        (rd_o),
        .grant_o     (grant_o),
        .grant_id_o  (grant_id_o),
        .valid_o     (valid_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int id;
        int len;
    } txn_t;

    int           n_checks = 0;
    int           n_fail   = 0;
    int           cnt[N];
    int           eop_rem[N];
    txn_t         exp_q[$];
    txn_t         cur;
    bit           in_grant      = 1'b0;
    int           beats         = 0;
    bit           prev_idle_req = 1'b0;
    bit           toggle_ready  = 1'b0;
    logic [N-1:0] rd_seen       = '0;
    int           mdl_last      = N - 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            fifo_empty_i[i] = (cnt[i] == 0);
            eop_i[i]        = (cnt[i] > 0) && (eop_rem[i] == 1);
        end
    endtask

    task automatic load(input int p, input int words, input int eop_at);
        cnt[p]     += words;
        eop_rem[p]  = eop_at;
    endtask

    // Transaction-level reference: round-robin order, burst or packet length.
    task automatic gen_expected();
        int   c[N];
        int   e[N];
        int   last;
        int   idx;
        txn_t t;
        for (int i = 0; i < N; i++) begin
            c[i] = cnt[i];
            e[i] = eop_rem[i];
        end
        last = mdl_last;
        for (int guard = 0; guard < 64; guard++) begin
            idx = -1;
            for (int k = 1; k <= N; k++) begin
                int j;
                j = (last + k) % N;
                if (idx < 0 && (LOCK ? (e[j] > 0) : (c[j] > 0))) idx = j;
            end
            if (idx < 0) break;
            t.id = idx;
            if (LOCK) begin
                t.len  = e[idx];
                e[idx] = 0;
                c[idx] = 0;
            end else begin
                t.len   = (c[idx] > MB) ? MB : c[idx];
                c[idx] -= t.len;
            end
            exp_q.push_back(t);
            last = idx;
        end
        mdl_last = last;
    endtask

    task automatic monitor();
        rd_seen = rd_o;
        check_eq("rd_onehot", 32'($onehot0(rd_o)), 32'(1));
        check_eq("rd_to_empty", 32'(rd_o & fifo_empty_i), 32'(0));
        check_eq("rd_not_ready", 32'((rd_o != '0) && !out_ready_i), 32'(0));
        check_eq("rd_outside_grant", 32'(rd_o & ~grant_o), 32'(0));
        if (prev_idle_req) check_eq("idle_gap", 32'(busy_o), 32'(1));
        if (busy_o) begin
            if (!in_grant) begin
                if (exp_q.size() == 0) begin
                    check_eq("grant_unexpected", 32'(exp_q.size()), 32'(1));
                end else begin
                    cur      = exp_q.pop_front();
                    in_grant = 1'b1;
                    beats    = 0;
                    check_eq("grant_id", 32'(grant_id_o), 32'(cur.id));
                end
            end
            if (in_grant) begin
                check_eq("grant_oh", 32'(grant_o), 32'(N'(1) << cur.id));
                check_eq("valid", 32'(valid_o), 32'(!fifo_empty_i[cur.id]));
                if (rd_o != '0) beats++;
            end
        end else begin
            check_eq("idle_grant", 32'(grant_o), 32'(0));
            check_eq("idle_valid", 32'(valid_o), 32'(0));
            if (in_grant) begin
                check_eq("burst_len", 32'(beats), 32'(cur.len));
                check_eq("id_hold", 32'(grant_id_o), 32'(cur.id));
                in_grant = 1'b0;
            end
        end
        prev_idle_req = !busy_o && (fifo_empty_i != '1);
    endtask

    task automatic step();
        @(negedge clk_i);
        monitor();
        @(posedge clk_i);
        #1;
        for (int i = 0; i < N; i++) begin
            if (rd_seen[i]) begin
                if (cnt[i] > 0) cnt[i]--;
                if (eop_rem[i] > 0) eop_rem[i]--;
            end
        end
        if (toggle_ready) out_ready_i = !out_ready_i;
        drive();
    endtask

    task automatic run_until_done(input int max_cyc);
        for (int k = 0; k < max_cyc; k++) begin
            step();
            if (exp_q.size() == 0 && !in_grant) break;
        end
        check_eq("drain_done", 32'(exp_q.size() + int'(in_grant)), 32'(0));
        step();
        step();
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_rd"}, 32'(rd_o), 32'(0));
        check_eq({tag, "_grant"}, 32'(grant_o), 32'(0));
        check_eq({tag, "_id"}, 32'(grant_id_o), 32'(0));
        check_eq({tag, "_valid"}, 32'(valid_o), 32'(0));
        check_eq({tag, "_busy"}, 32'(busy_o), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            cnt[i]     = 0;
            eop_rem[i] = 0;
        end
        rst_ni      = 1'b0;
        out_ready_i = 1'b1;

        // FIFOs 1 and 3 already hold data while reset is low, so rd_o must
        // stay quiet.
        load(1, 3, 3);
        load(3, 6, 6);
        drive();
        @(negedge clk_i);
        check_all_zero("reset");
        #2 rst_ni = 1'b1;
        mdl_last = N - 1;
        gen_expected();
        run_until_done(200);

        // All four FIFOs full. In burst mode eop arrives early and must be
        // ignored.
        for (int i = 0; i < N; i++) load(i, 8, LOCK ? 8 : 2);
        drive();
        gen_expected();
        run_until_done(400);

        // Stall: ready toggles every cycle while FIFO 2 owns the port.
        load(2, 4, 4);
        drive();
        gen_expected();
        toggle_ready = 1'b1;
        run_until_done(200);
        toggle_ready = 1'b0;
        out_ready_i  = 1'b1;
        drive();

        // Reset in the middle of a FIFO 2 transfer.
        load(2, 8, 8);
        drive();
        gen_expected();
        for (int k = 0; k < 50; k++) begin
            if (in_grant && beats >= 2) break;
            step();
        end
        check_eq("mid_xfer_reached", 32'(in_grant && beats >= 2), 32'(1));
        #2 rst_ni = 1'b0;
        #1 check_all_zero("async_reset");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            check_eq("reset_rd", 32'(rd_o), 32'(0));
            check_eq("reset_busy", 32'(busy_o), 32'(0));
        end
        exp_q.delete();
        in_grant      = 1'b0;
        prev_idle_req = 1'b0;
        rd_seen       = '0;
        mdl_last      = N - 1;
        load(0, 2, 2);
        drive();
        gen_expected();
        #1 rst_ni = 1'b1;
        run_until_done(200);

`ifdef ROUTER_PKT_LOCK_EN
        // A six-word packet on FIFO 0 runs past MAX_BURST without handover.
        load(0, 6, 6);
        load(1, 3, 3);
        drive();
        gen_expected();
        run_until_done(200);

        // FIFO 0 runs dry mid-packet: the grant holds until the refill.
        load(0, 2, 4);
        drive();
        gen_expected();
        for (int k = 0; k < 50; k++) begin
            if (in_grant && beats >= 2) break;
            step();
        end
        for (int k = 0; k < 4; k++) begin
            step();
            check_eq("lock_hold_busy", 32'(busy_o), 32'(1));
            check_eq("lock_hold_rd", 32'(rd_o), 32'(0));
        end
        cnt[0] += 2;
        drive();
        run_until_done(200);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
